l2_cache_control: RTL

- FSM controller sequencing the 4-way, 8-set, 256-bit-line L2 cache datapath.
- Accepts one upstream line request at a time (mem_read/mem_write) and resolves hits in the compare state.
- On a miss, writes back a dirty victim, refills from physical memory and installs the line.
- Owns tree-PLRU replacement state and victim selection; drives every datapath load/select.

---
 rtl/cache_mux_types.sv | 33 +++
 rtl/l2_plru.sv | 37 +++
 rtl/l2_cache_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cache_mux_types.sv
// Shared select encodings and controller state for the L2 cache datapath.
package cache_mux_types;

    localparam int unsigned L2_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        no_write,
        cpu_write_cache,
        mem_write_cache
    } dataarraymux_sel_t;

    typedef enum logic {
        cache_read_mem,
        cache_write_mem
    } pmemaddressmux_sel_t;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL,
        INSTALL
    } l2_ctrl_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [1:0] first_set(input logic [3:0] v);
        first_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) first_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/l2_plru.sv
// Per-set 3-bit tree pseudo-LRU state with combinational victim lookup.
module l2_plru #(
    parameter int unsigned s_index = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_index-1:0] index,
    input  logic               update,
    input  logic [1:0]         way,
    output logic [1:0]         plru_victim
);

    localparam int unsigned Sets = 2 ** s_index;

    // Bit 0 is the root (b0), bit 1 guards ways 0/1 (b1), bit 2 guards ways 2/3 (b2).
    logic [2:0] bits_q [Sets];
    logic [2:0] bits_d;
    logic [2:0] cur;

    always_comb begin
        cur    = bits_q[index];
        bits_d = cur;
        bits_d[0] = ~way[1];
        if (!way[1]) bits_d[1] = ~way[0];
        else         bits_d[2] = ~way[0];
        plru_victim = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Sets; i++) bits_q[i] <= '0;
        end else if (update) begin
            bits_q[index] <= bits_d;
        end
    end

endmodule

// File: rtl/l2_cache_control.sv
// Controller FSM for the 4-way L2 cache: hit resolution, dirty writeback, refill and install.
module l2_cache_control
    import cache_mux_types::*;
#(
    parameter int unsigned s_index  = 3,
    parameter int unsigned num_ways = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         mem_address,
    output logic                mem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    input  logic                hit,
    input  logic [num_ways-1:0] way_hit,
    input  logic [num_ways-1:0] valid,
    input  logic [num_ways-1:0] dirty,
    output logic [num_ways-1:0] v_load,
    output logic [num_ways-1:0] v_datain,
    output logic [num_ways-1:0] d_load,
    output logic [num_ways-1:0] d_datain,
    output logic [num_ways-1:0] tag_load,
    output logic                memory_buffer_register_load,
    output dataarraymux_sel_t   write_en_MUX_sel [num_ways],
    output dataarraymux_sel_t   data_array_datain_MUX_sel [num_ways],
    output logic [1:0]          dataout_MUX_sel,
    output pmemaddressmux_sel_t pmem_address_MUX_sel
);

    l2_ctrl_state_t state_q, state_d;
    logic [1:0]     victim_q, victim_d;
    logic [1:0]     hit_way;
    logic [1:0]     plru_victim;
    logic           plru_update;
    logic           req;
    logic           unused_addr;

    assign req         = mem_read | mem_write;
    assign hit_way     = first_set(way_hit);
    assign unused_addr = ^{mem_address[31:L2_OFFSET_BITS+s_index],
                           mem_address[L2_OFFSET_BITS-1:0]};

    l2_plru #(
        .s_index(s_index)
    ) u_plru (
        .clk        (clk),
        .rst        (rst),
        .index      (mem_address[L2_OFFSET_BITS +: s_index]),
        .update     (plru_update),
        .way        (hit_way),
        .plru_victim(plru_victim)
    );

    always_comb begin
        state_d                     = state_q;
        victim_d                    = victim_q;
        plru_update                 = 1'b0;
        mem_resp                    = 1'b0;
        pmem_read                   = 1'b0;
        pmem_write                  = 1'b0;
        v_load                      = '0;
        v_datain                    = '0;
        d_load                      = '0;
        d_datain                    = '0;
        tag_load                    = '0;
        memory_buffer_register_load = 1'b0;
        dataout_MUX_sel             = victim_q;
        pmem_address_MUX_sel        = cache_read_mem;
        for (int w = 0; w < num_ways; w++) begin
            write_en_MUX_sel[w]          = no_write;
            data_array_datain_MUX_sel[w] = no_write;
        end

        unique case (state_q)
            IDLE: begin
                if (req) state_d = COMPARE;
            end
            COMPARE: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (hit) begin
                    dataout_MUX_sel = hit_way;
                    mem_resp        = 1'b1;
                    plru_update     = 1'b1;
                    state_d         = IDLE;
                    // mem_write wins when both request lines are high.
                    if (mem_write) begin
                        write_en_MUX_sel[hit_way]          = cpu_write_cache;
                        data_array_datain_MUX_sel[hit_way] = cpu_write_cache;
                        d_load[hit_way]                    = 1'b1;
                        d_datain[hit_way]                  = 1'b1;
                    end
                end else begin
                    victim_d = (&valid) ? plru_victim : first_set(~valid);
                    state_d  = (valid[victim_d] && dirty[victim_d]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write           = 1'b1;
                pmem_address_MUX_sel = cache_write_mem;
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    memory_buffer_register_load = 1'b1;
                    state_d                     = INSTALL;
                end
            end
            INSTALL: begin
                write_en_MUX_sel[victim_q]          = mem_write_cache;
                data_array_datain_MUX_sel[victim_q] = mem_write_cache;
                tag_load[victim_q]                  = 1'b1;
                v_load[victim_q]                    = 1'b1;
                v_datain[victim_q]                  = 1'b1;
                d_load[victim_q]                    = 1'b1;
                state_d                             = COMPARE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    onehot_way_hit_a: assert property (@(posedge clk) disable iff (!rst)
        (state_q == COMPARE && hit) |-> $onehot0(way_hit));

endmodule
